// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned Huffman codes MSB-first into bytes, with 0xFF->0x00 stuffing and 1-padding on flush.
// Latency: a byte completed by an input transfer at edge N is presented on byte_out after edge N+1.
// Backpressure: byte_out holds while !byte_ready; in_ready drops once fill exceeds ACC_W-CODE_W or during flush.
// Optional feature macro JPEG_PACKER_EOI_EN appends an 0xFF,0xD9 EOI marker after the padded tail.
module jpeg_bit_packer #(
    parameter int ACC_W  = 32,
    parameter int CODE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic [3:0]        code_len,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic              flush,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              done
);

    localparam int FW = $clog2(ACC_W + 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_STUFF,
        S_PAD,
`ifdef JPEG_PACKER_EOI_EN
        S_EOI_FF,
        S_EOI_D9,
`endif
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              flush_pend_q, flush_pend_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              done_q, done_d;

    logic              out_free;
    logic              in_xfer;
    logic              emit;
    logic [7:0]        emit_byte;
    logic [7:0]        pad_byte;
    logic [ACC_W-1:0]  acc_sh;
    logic [FW-1:0]     fill_sh;
    logic [CODE_W-1:0] code_mask;
    logic [ACC_W-1:0]  code_ext;
    logic [FW-1:0]     shamt;

    always_comb begin
        out_free  = !byte_valid_q || byte_ready;
        in_ready  = (state_q == S_RUN) && !flush_pend_q && (fill_q <= FW'(ACC_W - CODE_W));
        in_xfer   = valid_in && in_ready;
        pad_byte  = acc_q[ACC_W-1 -: 8] | (8'hFF >> fill_q[2:0]);

        emit         = 1'b0;
        emit_byte    = 8'h00;
        state_d      = state_q;
        done_d       = 1'b0;
        flush_pend_d = flush_pend_q | flush;
        acc_sh       = acc_q;
        fill_sh      = fill_q;

        case (state_q)
            S_RUN: begin
                if (fill_q >= FW'(8) && out_free) begin
                    emit      = 1'b1;
                    emit_byte = acc_q[ACC_W-1 -: 8];
                    acc_sh    = acc_q << 8;
                    fill_sh   = fill_q - FW'(8);
                    if (emit_byte == 8'hFF) begin
                        state_d = S_STUFF;
                    end
                end else if (fill_q < FW'(8) && flush_pend_q && out_free) begin
                    state_d = S_PAD;
                end
            end
            S_STUFF: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_byte = 8'h00;
                    state_d   = (flush_pend_q && fill_q < FW'(8)) ? S_PAD : S_RUN;
                end
            end
            S_PAD: begin
                // Bits below fill are always zero, so OR-ing the mask pads with 1s.
                if (fill_q != '0) begin
                    if (out_free) begin
                        emit      = 1'b1;
                        emit_byte = pad_byte;
                        acc_sh    = '0;
                        fill_sh   = '0;
                        if (pad_byte == 8'hFF) begin
                            state_d = S_STUFF;
                        end
                    end
                end else begin
`ifdef JPEG_PACKER_EOI_EN
                    state_d = S_EOI_FF;
`else
                    state_d = S_DRAIN;
`endif
                end
            end
`ifdef JPEG_PACKER_EOI_EN
            S_EOI_FF: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_byte = 8'hFF;
                    state_d   = S_EOI_D9;
                end
            end
            S_EOI_D9: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_byte = 8'hD9;
                    state_d   = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                if (out_free) begin
                    done_d       = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        // New code lands directly below whatever remains after this cycle's emit.
        code_mask = (CODE_W'(1) << code_len) - CODE_W'(1);
        code_ext  = ACC_W'(code_in & code_mask);
        shamt     = FW'(ACC_W) - fill_sh - FW'(code_len);
        acc_d     = acc_sh;
        fill_d    = fill_sh;
        if (in_xfer) begin
            acc_d  = acc_sh | (code_ext << shamt);
            fill_d = fill_sh + FW'(code_len);
        end

        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        if (emit) begin
            byte_out_d   = emit_byte;
            byte_valid_d = 1'b1;
        end else if (byte_ready) begin
            byte_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign done       = done_q;

endmodule
